rpn_stack_master: RTL and testbench
===================================

# rpn_stack_master

Command-side initiator for the 5-entry, 4-bit hardware stack. It accepts a token stream (literals, add, subtract, peek) over a valid/ready handshake. It turns each token into a sequence of stack push/pop/get commands, evaluating reverse-Polish expressions with the stack as operand storage. It sits between a token source and the stack, drives all of the stack's command inputs and reads its data output. It tracks stack depth itself, because the stack wraps silently on overflow and underflow.

## Interface
- No parameters. Stack depth is fixed at 5, data width at 4, index width at 3.
- CLK  in  1  single clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-high; also wired to the stack's RESET.
- TOK_VALID  in  1  token present.
- TOK_READY  out  1  master can accept a token; high only in IDLE.
- TOK_KIND  in  2  00 literal, 01 add, 10 sub, 11 peek.
- TOK_DATA  in  4  literal value (kind 00), or peek index in [2:0] (kind 11).
- S_COMMAND  out  2  to stack: 00 nop, 01 push, 10 pop, 11 get.
- S_INDEX  out  3  to stack get index; 0 = top of stack.
- S_I_DATA  out  4  to stack push data.
- S_O_DATA  in  4  from stack; combinationally valid during pop/get cycle.
- RES_VALID  out  1  one-cycle pulse: token completed successfully.
- RES_DATA  out  4  value pushed (literal/add/sub) or value read (peek); held until next RES_VALID.
- ERR  out  1  sticky error flag; cleared only by RESET.
- DEPTH  out  3  current stack occupancy 0..5.

## Operation
- Token accepted on a rising edge with TOK_VALID & TOK_READY; TOK_KIND/TOK_DATA latched into a token register.
- States: IDLE, PUSH_LIT, POP_A, POP_B, PUSH_R, GET, DONE.
- IDLE plus accept:
  - Literal with DEPTH<5 -> PUSH_LIT.
  - Add/sub with DEPTH>=2 -> POP_A.
  - Peek with TOK_DATA[2:0] < DEPTH -> GET.
  - Any other case: ERR set, token dropped, no stack command issued, stay in IDLE.
- PUSH_LIT: S_COMMAND=01, S_I_DATA=literal; DEPTH+1; result=literal -> DONE.
- POP_A: S_COMMAND=10; capture A=S_O_DATA (top); DEPTH-1 -> POP_B.
- POP_B: S_COMMAND=10; capture B=S_O_DATA; DEPTH-1 -> PUSH_R.
- PUSH_R: S_COMMAND=01, S_I_DATA = add ? B+A : B-A (4-bit); DEPTH+1 -> DONE.
- GET: S_COMMAND=11, S_INDEX=latched index; capture S_O_DATA; DEPTH unchanged -> DONE.
- DONE: RES_VALID=1, S_COMMAND=00 -> IDLE.
- S_COMMAND is 00 in IDLE and DONE. S_INDEX is 0 outside GET. S_I_DATA is 0 outside push states.
- ERR never blocks operation; later tokens still execute.

## Timing
- Reset values: TOK_READY=1, S_COMMAND=00, S_INDEX=0, S_I_DATA=0, RES_VALID=0, RES_DATA=0, ERR=0, DEPTH=0; state IDLE.
- S_COMMAND, S_INDEX and S_I_DATA are registered outputs, decoded from the registered state. Each stack command lasts exactly one CLK cycle.
- Pop/get data is sampled on the rising edge that ends the command cycle.
- Latency from accept edge to RES_VALID high:
  - literal 2 cycles;
  - add/sub 4 cycles;
  - peek 2 cycles;
  - rejected token never asserts RES_VALID.
- Back-to-back: TOK_READY returns high the cycle after DONE, so the next accept happens at the earliest 1 cycle after RES_VALID.
- RESET mid-sequence aborts immediately: the stack is reset by the same signal, so DEPTH=0 stays consistent. A partially executed add/sub leaves no trace.
- TOK_VALID with an X TOK_KIND in IDLE is illegal. TOK_KIND/TOK_DATA are ignored when not accepted.

## Configuration
- RPN_SAT_EN defined: add clamps to 15 on carry out; sub clamps to 0 when B<A.
- RPN_SAT_EN undefined: add and sub wrap modulo 16.

## Test plan
- Reset, then push literals 3, 9 -> S_COMMAND 01 sequence with data 3, 9; DEPTH=2; two RES_VALID pulses with RES_DATA 3, 9; ERR=0.
- After the previous scenario, sub token -> pops return 9 then 3; push 3-9. Unsaturated: RES_DATA=0xA. RPN_SAT_EN: RES_DATA=0. DEPTH=1; RES_VALID 4 cycles after accept.
- Push 5 literals 1..5, then a sixth literal 7 -> ERR=1, no push issued, DEPTH stays 5. Peek index 0 -> get with S_INDEX=0, RES_DATA=5. Peek index 4 -> RES_DATA=1.
- From empty, add token -> ERR=1, S_COMMAND stays 00, TOK_READY stays high. Peek index 0 on empty -> ERR stays 1, no get issued.
- Push 12, 7, then add: unsaturated RES_DATA=3; RPN_SAT_EN RES_DATA=15. Assert RESET during POP_B of a following add -> all outputs return to reset values asynchronously, DEPTH=0, ERR=0.

Source files
------------

// File: rtl/rpn_stack_master.sv
// rpn_stack_master: command-side initiator for a 5-entry, 4-bit hardware stack.
// It accepts literal/add/sub/peek tokens over valid/ready and turns each token
// into stack push/pop/get commands, evaluating reverse-Polish expressions.
// The stack wraps silently, so occupancy is tracked here and used to reject
// tokens that would overflow or underflow. A rejected token sets a sticky ERR.
// Optional feature macro: RPN_SAT_EN (saturating add/sub). When it is undefined,
// add and sub wrap modulo 16.
module rpn_stack_master (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       tok_valid_i,
    output logic       tok_ready_o,
    input  logic [1:0] tok_kind_i,
    input  logic [3:0] tok_data_i,
    output logic [1:0] s_command_o,
    output logic [2:0] s_index_o,
    output logic [3:0] s_i_data_o,
    input  logic [3:0] s_o_data_i,
    output logic       res_valid_o,
    output logic [3:0] res_data_o,
    output logic       err_o,
    output logic [2:0] depth_o
);

    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_PUSH = 2'b01;
    localparam logic [1:0] CMD_POP  = 2'b10;
    localparam logic [1:0] CMD_GET  = 2'b11;

    localparam logic [1:0] KIND_LIT  = 2'b00;
    localparam logic [1:0] KIND_ADD  = 2'b01;
    localparam logic [1:0] KIND_SUB  = 2'b10;
    localparam logic [1:0] KIND_PEEK = 2'b11;

    localparam logic [2:0] STACK_DEPTH = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PUSH_LIT = 3'd1,
        ST_POP_A    = 3'd2,
        ST_POP_B    = 3'd3,
        ST_PUSH_R   = 3'd4,
        ST_GET      = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    state_t     state_q;
    logic       tok_ready_q;
    logic       sub_q;        // latched operation: 1 = subtract, 0 = add
    logic [3:0] a_q;          // first popped operand (old top of stack)
    logic [2:0] depth_q;
    logic       err_q;
    logic       res_valid_q;
    logic [3:0] res_data_q;
    logic [1:0] s_command_q;
    logic [2:0] s_index_q;
    logic [3:0] s_i_data_q;

    logic [3:0] push_r_data_d;

    // Combine the two operands: B is the deeper operand, A the former top.
    function automatic logic [3:0] alu_f(input logic sub, input logic [3:0] b, input logic [3:0] a);
        logic [4:0] sum;
        logic [3:0] r;
        sum = {1'b0, b} + {1'b0, a};
`ifdef RPN_SAT_EN
        if (sub) begin
            if (b < a) begin
                r = 4'd0;
            end else begin
                r = b - a;
            end
        end else begin
            if (sum[4]) begin
                r = 4'd15;
            end else begin
                r = sum[3:0];
            end
        end
`else
        if (sub) begin
            r = b - a;
        end else begin
            r = sum[3:0];
        end
`endif
        return r;
    endfunction

    // Result of add/sub, formed while the second operand is on the stack's output.
    always_comb begin
        push_r_data_d = alu_f(sub_q, s_o_data_i, a_q);
    end

    // Token FSM with registered stack-command, handshake and result outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            tok_ready_q <= 1'b1;
            sub_q       <= 1'b0;
            a_q         <= 4'd0;
            depth_q     <= 3'd0;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= 4'd0;
            s_command_q <= CMD_NOP;
            s_index_q   <= 3'd0;
            s_i_data_q  <= 4'd0;
        end else begin
            res_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (tok_valid_i) begin
                        sub_q <= (tok_kind_i == KIND_SUB);
                        case (tok_kind_i)
                            KIND_LIT: begin
                                if (depth_q < STACK_DEPTH) begin
                                    state_q     <= ST_PUSH_LIT;
                                    tok_ready_q <= 1'b0;
                                    s_command_q <= CMD_PUSH;
                                    s_i_data_q  <= tok_data_i;
                                end else begin
                                    err_q <= 1'b1;
                                end
                            end
                            KIND_ADD, KIND_SUB: begin
                                if (depth_q >= 3'd2) begin
                                    state_q     <= ST_POP_A;
                                    tok_ready_q <= 1'b0;
                                    s_command_q <= CMD_POP;
                                end else begin
                                    err_q <= 1'b1;
                                end
                            end
                            KIND_PEEK: begin
                                if (tok_data_i[2:0] < depth_q) begin
                                    state_q     <= ST_GET;
                                    tok_ready_q <= 1'b0;
                                    s_command_q <= CMD_GET;
                                    s_index_q   <= tok_data_i[2:0];
                                end else begin
                                    err_q <= 1'b1;
                                end
                            end
                            default: begin
                                err_q <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_PUSH_LIT: begin
                    depth_q     <= depth_q + 3'd1;
                    res_data_q  <= s_i_data_q;
                    res_valid_q <= 1'b1;
                    s_command_q <= CMD_NOP;
                    s_i_data_q  <= 4'd0;
                    state_q     <= ST_DONE;
                end
                ST_POP_A: begin
                    a_q         <= s_o_data_i;
                    depth_q     <= depth_q - 3'd1;
                    s_command_q <= CMD_POP;
                    state_q     <= ST_POP_B;
                end
                ST_POP_B: begin
                    depth_q     <= depth_q - 3'd1;
                    s_command_q <= CMD_PUSH;
                    s_i_data_q  <= push_r_data_d;
                    state_q     <= ST_PUSH_R;
                end
                ST_PUSH_R: begin
                    depth_q     <= depth_q + 3'd1;
                    res_data_q  <= s_i_data_q;
                    res_valid_q <= 1'b1;
                    s_command_q <= CMD_NOP;
                    s_i_data_q  <= 4'd0;
                    state_q     <= ST_DONE;
                end
                ST_GET: begin
                    res_data_q  <= s_o_data_i;
                    res_valid_q <= 1'b1;
                    s_command_q <= CMD_NOP;
                    s_index_q   <= 3'd0;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    tok_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    tok_ready_q <= 1'b1;
                    s_command_q <= CMD_NOP;
                    s_index_q   <= 3'd0;
                    s_i_data_q  <= 4'd0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign tok_ready_o = tok_ready_q;
    assign s_command_o = s_command_q;
    assign s_index_o   = s_index_q;
    assign s_i_data_o  = s_i_data_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign err_o       = err_q;
    assign depth_o     = depth_q;

endmodule

// File: tb/tb_rpn_stack_master.sv
// Self-checking bench for rpn_stack_master: a behavioural 5-entry stack answers
// the master's commands, expected results are queued when tokens are driven and
// compared when RES_VALID pulses.
module tb_rpn_stack_master;

    logic       clk;
    logic       reset;
    logic       tok_valid;
    logic       tok_ready;
    logic [1:0] tok_kind;
    logic [3:0] tok_data;
    logic [1:0] s_command;
    logic [2:0] s_index;
    logic [3:0] s_i_data;
    logic [3:0] s_o_data;
    logic       res_valid;
    logic [3:0] res_data;
    logic       err;
    logic [2:0] depth;

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] exp_q[$];

    rpn_stack_master dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .tok_valid_i (tok_valid),
        .tok_ready_o (tok_ready),
        .tok_kind_i  (tok_kind),
        .tok_data_i  (tok_data),
        .s_command_o (s_command),
        .s_index_o   (s_index),
        .s_i_data_o  (s_i_data),
        .s_o_data_i  (s_o_data),
        .res_valid_o (res_valid),
        .res_data_o  (res_data),
        .err_o       (err),
        .depth_o     (depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stack: push/pop on the rising edge, combinational read port.
    logic [3:0] mem [0:4];
    int sp;
    int pos;
    int push_cnt = 0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp <= 0;
        end else begin
            case (s_command)
                2'b01: begin
                    if (sp < 5) mem[sp] <= s_i_data;
                    sp <= sp + 1;
                end
                2'b10: sp <= sp - 1;
                default: ;
            endcase
        end
    end

    always @(posedge clk) begin
        if (!reset && s_command == 2'b01) push_cnt <= push_cnt + 1;
    end

    always_comb begin
        s_o_data = 4'd0;
        pos = sp - 1 - ((s_command == 2'b11) ? int'(s_index) : 0);
        if ((s_command == 2'b10 || s_command == 2'b11) && pos >= 0 && pos < 5)
            s_o_data = mem[pos];
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Scoreboard: every result pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && res_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_res_valid", 1, 0);
            end else begin
                chk("res_data", int'(res_data), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic check_reset_vals(input string pfx);
        chk({pfx, "_tok_ready"}, int'(tok_ready), 1);
        chk({pfx, "_s_command"}, int'(s_command), 0);
        chk({pfx, "_s_index"},   int'(s_index),   0);
        chk({pfx, "_s_i_data"},  int'(s_i_data),  0);
        chk({pfx, "_res_valid"}, int'(res_valid), 0);
        chk({pfx, "_res_data"},  int'(res_data),  0);
        chk({pfx, "_err"},       int'(err),       0);
        chk({pfx, "_depth"},     int'(depth),     0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
    endtask

    // Drive one token; ok=1 means it must execute with result exp after lat cycles.
    task automatic send(input logic [1:0] kind, input logic [3:0] data,
                        input bit ok, input logic [3:0] exp, input int lat);
        int cyc;
        int exp_cmd;
        bit got;
        @(negedge clk);
        cyc = 0;
        while (!tok_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("tok_ready_before_send", int'(tok_ready), 1);
        tok_valid = 1'b1;
        tok_kind  = kind;
        tok_data  = data;
        @(posedge clk);
        #1;
        tok_valid = 1'b0;
        tok_kind  = 2'($urandom);
        tok_data  = 4'($urandom);
        if (ok) begin
            exp_q.push_back(exp);
            exp_cmd = (kind == 2'b00) ? 1 : ((kind == 2'b11) ? 3 : 2);
            got = 1'b0;
            for (cyc = 1; cyc <= 10; cyc++) begin
                @(negedge clk);
                if (cyc == 1) begin
                    chk("first_cmd", int'(s_command), exp_cmd);
                    if (kind == 2'b11) chk("get_index", int'(s_index), int'(data[2:0]));
                    if (kind == 2'b00) chk("push_data", int'(s_i_data), int'(data));
                end
                if (res_valid) begin
                    got = 1'b1;
                    break;
                end
            end
            chk("latency", got ? cyc : 0, lat);
        end else begin
            chk("reject_err", int'(err), 1);
            chk("reject_ready", int'(tok_ready), 1);
            chk("reject_cmd", int'(s_command), 0);
            repeat (3) @(negedge clk);
        end
    endtask

    initial begin
        int pc;
        reset     = 1'b1;
        tok_valid = 1'b0;
        tok_kind  = 2'b00;
        tok_data  = 4'd0;
        #1;
        check_reset_vals("por");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Literals 3, 9 then subtract: 3 - 9.
        send(2'b00, 4'd3, 1'b1, 4'd3, 2);
        send(2'b00, 4'd9, 1'b1, 4'd9, 2);
        chk("depth_after_3_9", int'(depth), 2);
        chk("err_after_3_9", int'(err), 0);
`ifdef RPN_SAT_EN
        send(2'b10, 4'd0, 1'b1, 4'd0, 4);
`else
        send(2'b10, 4'd0, 1'b1, 4'hA, 4);
`endif
        chk("depth_after_sub", int'(depth), 1);

        // Fill the stack, overflow, then peek top and bottom.
        do_reset();
        for (int i = 1; i <= 5; i++) send(2'b00, 4'(i), 1'b1, 4'(i), 2);
        pc = push_cnt;
        send(2'b00, 4'd7, 1'b0, 4'd0, 0);
        chk("overflow_no_push", push_cnt, pc);
        chk("overflow_depth", int'(depth), 5);
        send(2'b11, 4'd0, 1'b1, 4'd5, 2);
        send(2'b11, 4'd4, 1'b1, 4'd1, 2);
        chk("peek_depth", int'(depth), 5);
        chk("res_data_held", int'(res_data), 1);

        // Underflowing add and out-of-range peek on an empty stack.
        do_reset();
        check_reset_vals("rst2");
        send(2'b01, 4'd0, 1'b0, 4'd0, 0);
        send(2'b11, 4'd0, 1'b0, 4'd0, 0);
        chk("empty_depth", int'(depth), 0);

        // 12 + 7, then reset in the middle of another add.
        do_reset();
        send(2'b00, 4'd12, 1'b1, 4'd12, 2);
        send(2'b00, 4'd7, 1'b1, 4'd7, 2);
`ifdef RPN_SAT_EN
        send(2'b01, 4'd0, 1'b1, 4'd15, 4);
`else
        send(2'b01, 4'd0, 1'b1, 4'd3, 4);
`endif
        chk("depth_after_add", int'(depth), 1);
        send(2'b00, 4'd4, 1'b1, 4'd4, 2);
        @(negedge clk);
        tok_valid = 1'b1;
        tok_kind  = 2'b01;
        tok_data  = 4'd0;
        @(posedge clk);
        #1;
        tok_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pop_b_cmd", int'(s_command), 2);
        chk("pop_b_depth", int'(depth), 1);
        reset = 1'b1;
        #1;
        check_reset_vals("async");
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();

        // Recovery after the aborted add.
        send(2'b00, 4'd6, 1'b1, 4'd6, 2);
        chk("recover_depth", int'(depth), 1);
        repeat (2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
